// File: rtl/sram_dp_param.sv
// sram_dp_param: true dual-port SRAM with per-bit write masks, selectable
// same-port read-during-write behaviour and an optional output pipeline stage.
module sram_dp_param #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen_a,
  input  logic                  wen_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wmsk_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_a,
  input  logic                  cen_b,
  input  logic                  wen_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wmsk_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_b,
  output logic                  collision
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Index 0 is port A, index 1 is port B, so both share one generate body.
  logic [ADDR_WIDTH-1:0] addr      [2];
  logic [DATA_WIDTH-1:0] wmsk      [2];
  logic [DATA_WIDTH-1:0] wdata     [2];
  logic [DATA_WIDTH-1:0] rdata     [2];
  logic [DATA_WIDTH-1:0] old_word  [2];
  logic [DATA_WIDTH-1:0] own_merge [2];
  logic [1:0]            cen;
  logic [1:0]            wen;
  logic [1:0]            rvalid;
  logic [1:0]            acc;
  logic [1:0]            wr;
  logic [1:0]            in_range;

  assign cen      = {cen_b, cen_a};
  assign wen      = {wen_b, wen_a};
  assign addr[0]  = addr_a;
  assign addr[1]  = addr_b;
  assign wmsk[0]  = wmsk_a;
  assign wmsk[1]  = wmsk_b;
  assign wdata[0] = wdata_a;
  assign wdata[1] = wdata_b;
  assign rdata_a  = rdata[0];
  assign rdata_b  = rdata[1];
  assign rvalid_a = rvalid[0];
  assign rvalid_b = rvalid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic                  rd_en;
      logic [DATA_WIDTH-1:0] rd_word;
      logic                  s1_valid_reg;
      logic [DATA_WIDTH-1:0] s1_data_reg;

      assign acc[gi]       = ~cen[gi];
      assign wr[gi]        = ~cen[gi] & ~wen[gi];
      assign in_range[gi]  = {1'b0, addr[gi]} < DEPTH_W;
      assign old_word[gi]  = in_range[gi] ? mem[addr[gi]] : '0;
      assign own_merge[gi] = (old_word[gi] & wmsk[gi]) | (wdata[gi] & ~wmsk[gi]);

      // No-change mode drops the read half of a write access entirely.
      assign rd_en   = acc[gi] & ~(wr[gi] & (WRITE_MODE == 2));
      assign rd_word = !in_range[gi]               ? '0 :
                       (wr[gi] && WRITE_MODE == 1) ? own_merge[gi] : old_word[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_reg <= 1'b0;
          s1_data_reg  <= '0;
        end else begin
          s1_valid_reg <= rd_en;
          if (rd_en) begin
            s1_data_reg <= rd_word;
          end
        end
      end

      if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid_reg;
        logic [DATA_WIDTH-1:0] s2_data_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
          end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
              s2_data_reg <= s1_data_reg;
            end
          end
        end

        assign rdata[gi]  = s2_data_reg;
        assign rvalid[gi] = s2_valid_reg;
      end else begin : g_out_direct
        assign rdata[gi]  = s1_data_reg;
        assign rvalid[gi] = s1_valid_reg;
      end
    end
  endgenerate

  // On a same-address dual write, A's word is built on top of B's so A wins
  // shared bits while bits only B unmasks still land.
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] wr_word_a;
  logic [DATA_WIDTH-1:0] wr_word_b;

  assign same_addr = (addr[0] == addr[1]);
  assign wr_word_b = own_merge[1];
  assign wr_word_a = (((wr[1] && same_addr) ? wr_word_b : old_word[0]) & wmsk[0]) |
                     (wdata[0] & ~wmsk[0]);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr[1] && in_range[1]) begin
        mem[addr[1]] <= wr_word_b;
      end
      if (wr[0] && in_range[0]) begin
        mem[addr[0]] <= wr_word_a;
      end
    end
  end

  logic collision_reg;
  logic collision_next;

  assign collision_next = acc[0] & acc[1] & same_addr & in_range[0] & (wr[0] | wr[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_reg <= 1'b0;
    end else begin
      collision_reg <= collision_next;
    end
  end

  assign collision = collision_reg;

endmodule

// File: tb/tb_sram_dp_param.sv
// tb_sram_dp_param: four instances (read-first, write-first, no-change, read-first
// with output register) share one stimulus stream and one behavioural memory model.
module tb_sram_dp_param;
  localparam int DW    = 18;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;
  localparam int NI    = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen_a = 1'b1, wen_a = 1'b1, cen_b = 1'b1, wen_b = 1'b1;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wmsk_a = '1, wmsk_b = '1, wdata_a = '0, wdata_b = '0;

  logic [DW-1:0] rdata_a [NI];
  logic [DW-1:0] rdata_b [NI];
  logic          rvalid_a [NI];
  logic          rvalid_b [NI];
  logic          collision [NI];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      sram_dp_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .WRITE_MODE(gi == 1 ? 1 : (gi == 2 ? 2 : 0)),
        .OUT_REG(gi == 3 ? 1 : 0)
      ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cen_a(cen_a), .wen_a(wen_a), .addr_a(addr_a), .wmsk_a(wmsk_a),
        .wdata_a(wdata_a), .rdata_a(rdata_a[gi]), .rvalid_a(rvalid_a[gi]),
        .cen_b(cen_b), .wen_b(wen_b), .addr_b(addr_b), .wmsk_b(wmsk_b),
        .wdata_b(wdata_b), .rdata_b(rdata_b[gi]), .rvalid_b(rvalid_b[gi]),
        .collision(collision[gi])
      );
    end
  endgenerate

  // Reference model state: memory contents plus what each port should be showing.
  logic [DW-1:0] mem_m   [1 << AW];
  int            mode_of [NI] = '{0, 1, 2, 0};
  int            lat_of  [NI] = '{1, 1, 1, 2};
  logic [DW-1:0] shown_d [NI][2];
  logic [DW-1:0] pend_d  [NI][2];
  bit            pend_v  [NI][2];
  bit            exp_v   [NI][2];
  bit            exp_coll;

  int checks   = 0;
  int errors   = 0;
  bit checking = 1'b0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        shown_d[i][p] = '0;
        pend_d[i][p]  = '0;
        pend_v[i][p]  = 1'b0;
        exp_v[i][p]   = 1'b0;
      end
    end
    exp_coll = 1'b0;
  endtask

  // Applies the currently driven inputs to the model as of the coming clock edge.
  task automatic model_edge();
    logic [AW-1:0] ad  [2];
    logic [DW-1:0] wd  [2];
    logic [DW-1:0] wm  [2];
    logic [DW-1:0] old [2];
    bit            acc [2];
    bit            wr  [2];
    bit            inr [2];
    bit            rsp_v;
    logic [DW-1:0] rsp_d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ad[0] = addr_a;  ad[1] = addr_b;
    wd[0] = wdata_a; wd[1] = wdata_b;
    wm[0] = wmsk_a;  wm[1] = wmsk_b;
    acc[0] = !cen_a; acc[1] = !cen_b;
    wr[0]  = acc[0] && !wen_a;
    wr[1]  = acc[1] && !wen_b;
    for (int p = 0; p < 2; p++) begin
      inr[p] = int'(ad[p]) < DEPTH;
      old[p] = inr[p] ? mem_m[ad[p]] : '0;
    end
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        rsp_v = acc[p] && !(wr[p] && mode_of[i] == 2);
        if (!inr[p])                     rsp_d = '0;
        else if (wr[p] && mode_of[i] == 1) rsp_d = (old[p] & wm[p]) | (wd[p] & ~wm[p]);
        else                              rsp_d = old[p];
        if (lat_of[i] == 1) begin
          exp_v[i][p] = rsp_v;
          if (rsp_v) shown_d[i][p] = rsp_d;
        end else begin
          exp_v[i][p] = pend_v[i][p];
          if (pend_v[i][p]) shown_d[i][p] = pend_d[i][p];
          pend_v[i][p] = rsp_v;
          pend_d[i][p] = rsp_d;
        end
      end
    end
    exp_coll = acc[0] && acc[1] && (ad[0] == ad[1]) && inr[0] && (wr[0] || wr[1]);
    // B lands first and A on top, so A wins bits both ports unmask.
    if (wr[1] && inr[1]) mem_m[ad[1]] = (mem_m[ad[1]] & wm[1]) | (wd[1] & ~wm[1]);
    if (wr[0] && inr[0]) mem_m[ad[0]] = (mem_m[ad[0]] & wm[0]) | (wd[0] & ~wm[0]);
  endtask

  task automatic compare_all(string what);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s i%0d rvalid_a", what, i), rvalid_a[i], exp_v[i][0]);
      check_eq($sformatf("%s i%0d rvalid_b", what, i), rvalid_b[i], exp_v[i][1]);
      check_eq($sformatf("%s i%0d rdata_a", what, i), rdata_a[i], shown_d[i][0]);
      check_eq($sformatf("%s i%0d rdata_b", what, i), rdata_b[i], shown_d[i][1]);
      check_eq($sformatf("%s i%0d collision", what, i), collision[i], exp_coll);
    end
  endtask

  task automatic step(string what);
    model_edge();
    @(posedge clk);
    #1;
    if (checking) begin
      compare_all(what);
      $display("%0t %-12s rst_n=%0b A:c%0b w%0b @%0d d=%05h m=%05h B:c%0b w%0b @%0d d=%05h m=%05h",
               $time, what, rst_n, cen_a, wen_a, addr_a, wdata_a, wmsk_a,
               cen_b, wen_b, addr_b, wdata_b, wmsk_b);
    end
  endtask

  task automatic port_a(bit c, bit w, int a, logic [DW-1:0] d, logic [DW-1:0] m);
    cen_a = c; wen_a = w; addr_a = AW'(a); wdata_a = d; wmsk_a = m;
  endtask

  task automatic port_b(bit c, bit w, int a, logic [DW-1:0] d, logic [DW-1:0] m);
    cen_b = c; wen_b = w; addr_b = AW'(a); wdata_b = d; wmsk_b = m;
  endtask

  task automatic idle();
    port_a(1'b1, 1'b1, 0, '0, '1);
    port_b(1'b1, 1'b1, 0, '0, '1);
  endtask

  // Asserts rst_n between clock edges, checks the immediate clear, and drives
  // a write during reset that must not reach memory.
  task automatic async_reset(int hold);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    port_a(1'b0, 1'b0, 5, '0, '0);
    port_b(1'b0, 1'b0, 9, '0, '0);
    repeat (hold) step("in_reset");
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) mem_m[k] = 'x;
    model_reset();

    // Reset state with clock running.
    checking = 1'b1;
    step("reset0");
    step("reset1");

    // Fill memory without checking (power-up contents are undefined), then reset.
    checking = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH / 2; k++) begin
      port_a(1'b0, 1'b0, k, DW'($urandom), '0);
      port_b(1'b0, 1'b0, k + DEPTH / 2, DW'($urandom), '0);
      step("init");
    end
    idle();
    step("init_idle");
    checking = 1'b1;
    async_reset(2);
    step("post_rst");

    // Masked write then read.
    port_a(1'b0, 1'b0, 5, 18'h3FFFF, '0);     step("wr5_full");
    port_a(1'b0, 1'b0, 5, 18'h00000, 18'h0FFFF); step("wr5_mask");
    port_a(1'b0, 1'b1, 5, '0, '1);            step("rd5");
    check_eq("masked_rd5", rdata_a[0], 18'h0FFFF);

    // Write-mode sweep on addr 7.
    port_a(1'b0, 1'b0, 7, 18'h00011, '0);     step("wr7_11");
    port_a(1'b0, 1'b0, 7, 18'h00022, '0);     step("wr7_22");
    check_eq("mode0_rdf", rdata_a[0], 18'h00011);
    check_eq("mode1_wrf", rdata_a[1], 18'h00022);
    check_eq("mode2_norv", rvalid_a[2], 1'b0);

    // Dual write collision on addr 3.
    port_a(1'b0, 1'b0, 3, 18'h00AAA, '0);
    port_b(1'b0, 1'b0, 3, 18'h00555, '0);     step("dual_wr3");
    check_eq("coll_dual", collision[0], 1'b1);
    check_eq("coll_dual_oreg", collision[3], 1'b1);
    idle();
    port_a(1'b0, 1'b1, 3, '0, '1);            step("rd3");
    check_eq("dual_wr3_win", rdata_a[0], 18'h00AAA);

    // Partial-mask dual write: A owns low byte, B owns bits 15:8.
    port_a(1'b0, 1'b0, 4, 18'h000CC, 18'h3FF00);
    port_b(1'b0, 1'b0, 4, 18'h0DD00, 18'h300FF); step("dual_wr4");
    idle();
    port_b(1'b0, 1'b1, 4, '0, '1);            step("rd4");

    // Cross-port read during write on addr 9.
    idle();
    port_a(1'b0, 1'b0, 9, 18'h00001, '0);     step("wr9_1");
    port_a(1'b0, 1'b0, 9, 18'h00002, '0);
    port_b(1'b0, 1'b1, 9, '0, '1);            step("xrd9");
    check_eq("xport_old", rdata_b[0], 18'h00001);
    check_eq("xport_coll", collision[0], 1'b1);
    port_a(1'b1, 1'b1, 0, '0, '1);            step("rd9_again");
    check_eq("xport_new", rdata_b[0], 18'h00002);

    // Streaming reads of 0..3.
    idle();
    for (int k = 0; k < 4; k++) begin
      port_a(1'b0, 1'b1, k, '0, '1);
      step($sformatf("stream%0d", k));
    end
    idle();
    step("stream_tail");
    check_eq("stream_last_valid", rvalid_a[3], 1'b1);
    step("stream_done");
    check_eq("stream_end", rvalid_a[3], 1'b0);

    // Reset with a read in flight through the output register.
    port_a(1'b0, 1'b1, 5, '0, '1);            step("rd_inflight");
    async_reset(1);
    step("after_rst");
    check_eq("inflight_dropped", rvalid_a[3], 1'b0);
    port_a(1'b0, 1'b1, 5, '0, '1);            step("rd5_kept");
    check_eq("mem_retained", rdata_a[0], 18'h0FFFF);

    // Out-of-range write, read and no collision.
    port_a(1'b0, 1'b0, 1000, 18'h12345, '0);
    port_b(1'b0, 1'b0, 1000, 18'h2ABCD, '0);  step("oor_wr");
    check_eq("oor_no_coll", collision[0], 1'b0);
    port_b(1'b1, 1'b1, 0, '0, '1);
    port_a(1'b0, 1'b1, 1000, '0, '1);         step("oor_rd");
    check_eq("oor_rd_zero", rdata_a[0], 18'h0);
    check_eq("oor_rd_valid", rvalid_a[0], 1'b1);

    // Random traffic over a small hot set plus out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) async_reset(1);
      port_a(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
             ($urandom_range(0, 5) == 0) ? 1000 + $urandom_range(0, 23) : $urandom_range(0, 15),
             DW'($urandom), ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom));
      port_b(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
             ($urandom_range(0, 5) == 0) ? 1000 + $urandom_range(0, 23) : $urandom_range(0, 15),
             DW'($urandom), ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom));
      step("random");
    end
    idle();
    step("drain0");
    step("drain1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_param.md
SRAM_DP_PARAM -- requirements
Module: sram_dp_param

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_WIDTH, default 18: bits per word, 1..72.
REQ-003 Parameter ADDR_WIDTH, default 10: address bits per port.
REQ-004 Parameter DEPTH, default 1024: number of words, at most 2**ADDR_WIDTH.
REQ-005 Parameter WRITE_MODE, default 0: same-port read-during-write; 0 read-first, 1 write-first, 2 no-change.
REQ-006 Parameter OUT_REG, default 0: 1 adds an output pipeline register on both ports.
REQ-007 clk  input  1  rising-edge clock for all logic.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 cen_a / cen_b  input  1  port enable, active-low.
REQ-010 wen_a / wen_b  input  1  write enable, active-low, qualified by cen.
REQ-011 addr_a / addr_b  input  ADDR_WIDTH  word address.
REQ-012 wmsk_a / wmsk_b  input  DATA_WIDTH  per-bit write mask; 0 writes the bit, 1 protects it.
REQ-013 wdata_a / wdata_b  input  DATA_WIDTH  write data.
REQ-014 rdata_a / rdata_b  output  DATA_WIDTH  registered read data.
REQ-015 rvalid_a / rvalid_b  output  1  one-cycle pulse, aligned with new rdata.
REQ-016 collision  output  1  one-cycle pulse flagging a same-address conflict.

Function
REQ-017 A port access SHALL occur on a rising clk edge when its cen is 0 and rst_n is 1; cen=1 means no access and rdata holds.
REQ-018 A write access (wen=0) SHALL update bit i of mem[addr] only where wmsk[i]=0.
REQ-019 Every access SHALL return a read unless REQ-022 applies: rdata and rvalid one edge after the access for OUT_REG=0, two edges after for OUT_REG=1.
REQ-020 In WRITE_MODE 0, a write access SHALL return the pre-write word.
REQ-021 In WRITE_MODE 1, a write access SHALL return the merged word: wdata on unmasked bits, old data on masked bits.
REQ-022 In WRITE_MODE 2, a write access SHALL leave rdata unchanged and SHALL NOT pulse rvalid.
REQ-023 A cross-port read of an address the other port writes in the same cycle SHALL return pre-write data, in every WRITE_MODE.
REQ-024 When both ports write the same address in one cycle, port A SHALL win on bits unmasked by both; other bits follow whichever port unmasks them.
REQ-025 collision SHALL pulse one edge after any cycle in which both ports access the same in-range address and at least one writes; it is independent of OUT_REG.
REQ-026 An address >= DEPTH SHALL drop writes and return an all-zero read with a normal rvalid pulse; it SHALL NOT raise collision.
REQ-027 With OUT_REG=1, the second stage SHALL load only when the first stage is valid, so back-to-back reads stream at one word per cycle.

Reset
REQ-028 While rst_n=0, rdata_a, rdata_b, all pipeline registers, rvalid_a, rvalid_b and collision SHALL be 0, taking effect immediately without a clock edge.
REQ-029 Accesses presented while rst_n=0 SHALL be ignored, with no memory writes.
REQ-030 Memory contents SHALL NOT be reset: they are undefined after power-up and retained across rst_n assertion.
REQ-031 A read in flight when rst_n asserts SHALL be discarded: no rvalid after deassertion.

Verification
REQ-032 Masked write, then read: A writes 0x3FFFF to addr 5, then writes 0x00000 with wmsk=0x0FFFF; read of addr 5 returns 0x0FFFF one cycle after the read access (OUT_REG=0).
REQ-033 WRITE_MODE sweep: addr 7 holds 0x00011; A writes 0x00022 -> rdata_a=0x00011 for mode 0, 0x00022 for mode 1, unchanged with no rvalid for mode 2.
REQ-034 Dual-write collision: A writes 0x00AAA and B writes 0x00555, both to addr 3 with all bits unmasked -> collision pulses next cycle; a later read of addr 3 returns 0x00AAA.
REQ-035 Cross-port read: addr 9 holds 0x00001; A writes 0x00002 to addr 9 while B reads it -> rdata_b=0x00001, collision=1; the next B read returns 0x00002.
REQ-036 OUT_REG=1 streaming: reads of addrs 0..3 on consecutive cycles -> rvalid_a high for 4 cycles starting 2 edges after the first access, with data in address order.
REQ-037 Reset mid-read and out-of-range: assert rst_n between access and response -> no rvalid afterward and memory retained; with DEPTH=1000, a read of addr 1000 returns 0 with rvalid=1.
